// File: rtl/sync_ram_sdp_be_if.sv
// Bus bundle for the byte-enable simple-dual-port RAM.
// The master drives the write and read ports; the slave returns read data and its valid flag.
interface sync_ram_sdp_be_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned BYTE_WIDTH    = 8
);
    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                     write_enable;
    logic [NUM_BYTES-1:0]     byte_enable;
    logic [ADDRESS_WIDTH-1:0] address_in_w;
    logic [DATA_WIDTH-1:0]    data_in;
    logic                     read_enable;
    logic [ADDRESS_WIDTH-1:0] address_in_r;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     data_valid;

    modport master (
        output write_enable, byte_enable, address_in_w, data_in,
        output read_enable, address_in_r,
        input  data_out, data_valid
    );

    modport slave (
        input  write_enable, byte_enable, address_in_w, data_in,
        input  read_enable, address_in_r,
        output data_out, data_valid
    );
endinterface

// File: rtl/sync_ram_sdp_be.sv
// Simple-dual-port synchronous RAM with per-byte write enables, selectable read-during-write
// behaviour, optional output register, synchronous output reset and a read-data valid flag.
module sync_ram_sdp_be #(
    parameter int unsigned            DATA_WIDTH    = 32,
    parameter int unsigned            ADDRESS_WIDTH = 10,
    parameter int unsigned            BYTE_WIDTH    = 8,
    parameter int unsigned            RDW_MODE      = 0,
    parameter int unsigned            OUTPUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    sync_ram_sdp_be_if.slave     bus
);
    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH     = 2 ** ADDRESS_WIDTH;

    generate
        if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
            $error("sync_ram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (RDW_MODE > 1) begin : g_bad_rdw
            $error("sync_ram_sdp_be: RDW_MODE must be 0 or 1");
        end
        if (OUTPUT_REG > 1) begin : g_bad_oreg
            $error("sync_ram_sdp_be: OUTPUT_REG must be 0 or 1");
        end
    endgenerate

    logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] mem [0:DEPTH-1];
    logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0]                s1_data;
    logic                                 s1_valid;

    // Memory has no reset so it still maps onto block RAM; only writes are gated by rst.
    always_ff @(posedge clk) begin
        if (bus.write_enable && !rst) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (bus.byte_enable[i]) begin
                    mem[bus.address_in_w][i] <= bus.data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Write-through bypass lives outside the array as an address-compare lane mux.
    always_comb begin
        rd_word = mem[bus.address_in_r];
        if ((RDW_MODE == 1) && bus.write_enable && (bus.address_in_w == bus.address_in_r)) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (bus.byte_enable[i]) begin
                    rd_word[i] = bus.data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= RESET_VALUE;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= bus.read_enable;
            if (bus.read_enable) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (OUTPUT_REG == 1) begin : g_oreg
            logic [DATA_WIDTH-1:0] s2_data;
            logic                  s2_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_data  <= RESET_VALUE;
                    s2_valid <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign bus.data_out   = s2_data;
            assign bus.data_valid = s2_valid;
        end else begin : g_noreg
            assign bus.data_out   = s1_data;
            assign bus.data_valid = s1_valid;
        end
    endgenerate
endmodule

// File: tb/tb_sync_ram_sdp_be.sv
// Bench for sync_ram_sdp_be: three configurations share one stimulus stream and are checked
// every cycle against a queue-based behavioural model, plus directed literal checks.
module tb_sync_ram_sdp_be;
    logic        clk = 1'b0;
    logic        rst, we, re;
    logic [3:0]  be;
    logic [9:0]  waddr, raddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: defaults; b: AW=4, write-through, output register, nonzero reset value; c: write-through only
    sync_ram_sdp_be_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(10), .BYTE_WIDTH(8)) ifa ();
    sync_ram_sdp_be_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4),  .BYTE_WIDTH(8)) ifb ();
    sync_ram_sdp_be_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(10), .BYTE_WIDTH(8)) ifc ();

    sync_ram_sdp_be #(.DATA_WIDTH(32), .ADDRESS_WIDTH(10), .BYTE_WIDTH(8), .RDW_MODE(0),
                      .OUTPUT_REG(0), .RESET_VALUE(32'h0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    sync_ram_sdp_be #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8), .RDW_MODE(1),
                      .OUTPUT_REG(1), .RESET_VALUE(32'h5A5A5A5A))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    sync_ram_sdp_be #(.DATA_WIDTH(32), .ADDRESS_WIDTH(10), .BYTE_WIDTH(8), .RDW_MODE(1),
                      .OUTPUT_REG(0), .RESET_VALUE(32'h0))
        dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    assign ifa.write_enable = we;   assign ifb.write_enable = we;   assign ifc.write_enable = we;
    assign ifa.byte_enable  = be;   assign ifb.byte_enable  = be;   assign ifc.byte_enable  = be;
    assign ifa.data_in      = wdata; assign ifb.data_in     = wdata; assign ifc.data_in     = wdata;
    assign ifa.read_enable  = re;   assign ifb.read_enable  = re;   assign ifc.read_enable  = re;
    assign ifa.address_in_w = waddr; assign ifc.address_in_w = waddr;
    assign ifa.address_in_r = raddr; assign ifc.address_in_r = raddr;
    assign ifb.address_in_w = waddr[3:0];
    assign ifb.address_in_r = raddr[3:0];

    logic [31:0] dout [3];
    logic        dv   [3];
    assign dout[0] = ifa.data_out; assign dv[0] = ifa.data_valid;
    assign dout[1] = ifb.data_out; assign dv[1] = ifb.data_valid;
    assign dout[2] = ifc.data_out; assign dv[2] = ifc.data_valid;

    function automatic int lat_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction
    function automatic bit rdw_of(input int k);
        return (k != 0);
    endfunction
    function automatic int unsigned amask_of(input int k);
        return (k == 1) ? 32'd15 : 32'd1023;
    endfunction
    function automatic logic [31:0] rv_of(input int k);
        return (k == 1) ? 32'h5A5A5A5A : 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each read becomes a pending result due LATENCY-1 edges after it is sampled;
    // a reset edge discards everything pending and forces the reset value.
    typedef struct {
        int          dut;
        int          due;
        logic [31:0] d;
    } pend_t;

    pend_t       pendq[$];
    logic [31:0] mm [3][1024];
    logic [31:0] exp_d [3];
    logic        exp_v [3];
    int          edge_n = 0;
    bit          armed  = 1'b0;

    task automatic model_step();
        int unsigned ra, wa;
        logic [31:0] rd;
        edge_n++;
        if (rst) begin
            armed = 1'b1;
            pendq.delete();
            for (int k = 0; k < 3; k++) begin
                exp_d[k] = rv_of(k);
                exp_v[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                ra = 32'(raddr) & amask_of(k);
                wa = 32'(waddr) & amask_of(k);
                if (re) begin
                    rd = mm[k][ra];
                    if (rdw_of(k) && we && (wa == ra)) begin
                        for (int l = 0; l < 4; l++) if (be[l]) rd[l*8 +: 8] = wdata[l*8 +: 8];
                    end
                    pendq.push_back('{k, edge_n + lat_of(k) - 1, rd});
                end
                if (we) begin
                    for (int l = 0; l < 4; l++) if (be[l]) mm[k][wa][l*8 +: 8] = wdata[l*8 +: 8];
                end
                exp_v[k] = 1'b0;
                for (int i = pendq.size() - 1; i >= 0; i--) begin
                    if (pendq[i].dut == k && pendq[i].due == edge_n) begin
                        exp_d[k] = pendq[i].d;
                        exp_v[k] = 1'b1;
                        pendq.delete(i);
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step();
            if (armed) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("data_out[%0d]", k), dout[k], exp_d[k]);
                    chk($sformatf("data_valid[%0d]", k), 32'(dv[k]), 32'(exp_v[k]));
                end
            end
        end
    end

    task automatic cyc(input bit r, input bit w, input logic [3:0] b, input int unsigned wa,
                       input logic [31:0] wd, input bit rd_en, input int unsigned ra);
        rst   = r;
        we    = w;
        be    = b;
        waddr = wa[9:0];
        wdata = wd;
        re    = rd_en;
        raddr = ra[9:0];
        @(negedge clk);
    endtask

    initial begin
        int unsigned wa, ra;
        rst = 1'b1; we = 1'b0; re = 1'b0; be = '0; waddr = '0; raddr = '0; wdata = '0;

        cyc(1, 0, 4'h0, 0, 32'h0, 0, 0);
        cyc(1, 0, 4'h0, 0, 32'h0, 1, 0);
        chk("reset_a_data", dout[0], 32'h0);
        chk("reset_a_valid", 32'(dv[0]), 32'h0);
        chk("reset_b_data", dout[1], 32'h5A5A5A5A);
        chk("reset_b_valid", 32'(dv[1]), 32'h0);

        for (int unsigned i = 0; i < 1024; i++) cyc(0, 1, 4'hF, i, $urandom, 0, 0);

        cyc(0, 1, 4'hF, 5, 32'hDEADBEEF, 0, 0);
        cyc(0, 0, 4'h0, 0, 32'h0, 1, 5);
        chk("basic_a_data", dout[0], 32'hDEADBEEF);
        chk("basic_a_valid", 32'(dv[0]), 32'h1);
        chk("basic_model", exp_d[0], 32'hDEADBEEF);

        cyc(0, 1, 4'hF, 7, 32'h11223344, 0, 0);
        cyc(0, 1, 4'b0101, 7, 32'hAABBCCDD, 0, 0);
        cyc(0, 0, 4'h0, 0, 32'h0, 1, 7);
        chk("bytemask_a", dout[0], 32'h11BB33DD);
        chk("bytemask_c", dout[2], 32'h11BB33DD);

        cyc(0, 1, 4'hF, 3, 32'h0, 0, 0);
        cyc(0, 1, 4'b0011, 3, 32'hFFFFFFFF, 1, 3);
        chk("rdw_old_a", dout[0], 32'h00000000);
        chk("rdw_new_c", dout[2], 32'h0000FFFF);
        chk("rdw_model_c", exp_d[2], 32'h0000FFFF);
        cyc(0, 0, 4'h0, 0, 32'h0, 1, 3);
        chk("rdw_after_a", dout[0], 32'h0000FFFF);
        chk("rdw_after_c", dout[2], 32'h0000FFFF);
        chk("rdw_new_b", dout[1], 32'h0000FFFF);

        cyc(0, 1, 4'hF, 0, 32'hA, 0, 0);
        cyc(0, 1, 4'hF, 1, 32'hB, 0, 0);
        cyc(0, 1, 4'hF, 2, 32'hC, 0, 0);
        cyc(0, 0, 4'h0, 0, 32'h0, 1, 0);
        chk("pipe_b_v0", 32'(dv[1]), 32'h0);
        cyc(0, 0, 4'h0, 0, 32'h0, 1, 1);
        chk("pipe_b_d1", dout[1], 32'hA);
        chk("pipe_b_v1", 32'(dv[1]), 32'h1);
        cyc(0, 0, 4'h0, 0, 32'h0, 1, 2);
        chk("pipe_b_d2", dout[1], 32'hB);
        chk("pipe_b_v2", 32'(dv[1]), 32'h1);
        cyc(0, 0, 4'h0, 0, 32'h0, 0, 0);
        chk("pipe_b_d3", dout[1], 32'hC);
        chk("pipe_b_v3", 32'(dv[1]), 32'h1);
        cyc(0, 0, 4'h0, 0, 32'h0, 0, 0);
        chk("pipe_b_d4", dout[1], 32'hC);
        chk("pipe_b_v4", 32'(dv[1]), 32'h0);

        cyc(0, 0, 4'h0, 0, 32'h0, 1, 0);
        cyc(1, 1, 4'hF, 1, 32'h12345678, 0, 0);
        chk("midrst_b_data", dout[1], 32'h5A5A5A5A);
        chk("midrst_b_valid", 32'(dv[1]), 32'h0);
        chk("midrst_model", exp_d[1], 32'h5A5A5A5A);
        cyc(0, 0, 4'h0, 0, 32'h0, 0, 0);
        chk("midrst_b_drop", 32'(dv[1]), 32'h0);
        chk("midrst_b_hold", dout[1], 32'h5A5A5A5A);
        cyc(0, 0, 4'h0, 0, 32'h0, 1, 1);
        cyc(0, 0, 4'h0, 0, 32'h0, 0, 0);
        chk("rstwrite_b", dout[1], 32'hB);
        chk("rstwrite_a", dout[0], 32'hB);

        cyc(0, 1, 4'hF, 0, 32'h0F0F0001, 0, 0);
        cyc(0, 1, 4'hF, 15, 32'hF0F0000F, 0, 0);
        cyc(0, 0, 4'h0, 0, 32'h0, 1, 0);
        cyc(0, 0, 4'h0, 0, 32'h0, 1, 15);
        chk("bound_a_15", dout[0], 32'hF0F0000F);
        chk("bound_b_0", dout[1], 32'h0F0F0001);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'h0, 0, 32'h0, 0, 0);
        chk("bound_b_hold", dout[1], 32'hF0F0000F);
        chk("bound_b_valid", 32'(dv[1]), 32'h0);
        chk("bound_a_hold", dout[0], 32'hF0F0000F);

        for (int n = 0; n < 3000; n++) begin
            wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 31);
            ra = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
            cyc($urandom_range(0, 49) == 0, 1'($urandom), 4'($urandom), wa, $urandom,
                1'($urandom), ra);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'h0, 0, 32'h0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_ram_sdp_be.md
Name: sync_ram_sdp_be

Overview:
- Simple-dual-port synchronous block RAM: one write port with per-byte write enables, one read port with read enable.
- Generalises the plain single-port and simple-dual-port RAMs with these additions:
  - selectable read-during-write (RDW) behaviour;
  - optional output pipeline register;
  - synchronous output reset;
  - a read-data valid flag.
- Used as the arch-test inference target for byte-enable BRAM mapping, and as a building block for FIFOs and register files.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDRESS_WIDTH, 10, address bits; depth = 2**ADDRESS_WIDTH words.
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- RDW_MODE, 0, same-address read during write: 0 = old data, 1 = new data (write-through).
- OUTPUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- RESET_VALUE, 0, DATA_WIDTH-bit value loaded into the output register(s) on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- write_enable  input  1  write strobe.
- byte_enable  input  NUM_BYTES  per-lane write mask; lane i covers data_in[i*BYTE_WIDTH +: BYTE_WIDTH].
- address_in_w  input  ADDRESS_WIDTH  write address.
- data_in  input  DATA_WIDTH  write data.
- read_enable  input  1  read strobe.
- address_in_r  input  ADDRESS_WIDTH  read address.
- data_out  output  DATA_WIDTH  registered read data.
- data_valid  output  1  high while data_out holds the result of a read issued LATENCY cycles earlier.

Behaviour:
- Reset:
  - On a clk edge with rst=1: data_out=RESET_VALUE, data_valid=0, internal stage-1 register=RESET_VALUE, stage-1 valid=0.
  - Memory contents are not cleared.
  - Writes are suppressed while rst=1. Reads issued with rst=1 are discarded.
- Write:
  - On an edge with write_enable=1 and rst=0, each lane i with byte_enable[i]=1 is updated. Other lanes keep their contents.
  - byte_enable all zero makes the cycle a no-op.
- Read, OUTPUT_REG=0:
  - On an edge with read_enable=1 and rst=0, data_out takes mem[address_in_r] and data_valid goes to 1.
  - With read_enable=0, data_out holds and data_valid goes to 0.
- Read, OUTPUT_REG=1:
  - Stage 1 captures as above.
  - Stage 2 (data_out, data_valid) copies stage 1 every cycle. Stage 2 holds data when stage-1 valid=0; data_valid follows the stage-1 valid.
  - Back-to-back reads give one result per cycle.
- Collision (write_enable=1, read_enable=1, address_in_w==address_in_r, same edge):
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns a per-lane merge. Enabled lanes come from data_in; disabled lanes come from the old word.
  - Different addresses: no interaction.
- Address range: all 2**ADDRESS_WIDTH addresses are valid; no out-of-range case exists. The memory array is declared [0:2**ADDRESS_WIDTH-1].
- Uninitialised words read as X in simulation; benches write before reading.
- Reset mid-pipeline: a read in flight in stage 1 is dropped. data_valid is 0 on the cycle after rst deasserts, and stays 0 until a new read completes.
- Parameter checks:
  - DATA_WIDTH % BYTE_WIDTH != 0 must raise an elaboration-time error via a generate-time $error.
  - RDW_MODE or OUTPUT_REG outside {0,1} likewise.
- The behavioural coding must stay inferable as BRAM. RDW_MODE=1 bypass logic sits outside the memory array as an address-compare mux.

Test Plan:
- Defaults: write 0xDEADBEEF to addr 5 with byte_enable=4'hF, then read addr 5 -> data_out=0xDEADBEEF and data_valid=1 one cycle after the read edge.
- Byte mask: addr 7 holds 0x11223344; write 0xAABBCCDD with byte_enable=4'b0101, then read addr 7 -> 0x11BB33DD.
- Collision, same edge: addr 3 holds 0x00000000; write 0xFFFFFFFF with byte_enable=4'b0011 and read addr 3.
  - RDW_MODE=0 -> 0x00000000.
  - RDW_MODE=1 -> 0x0000FFFF.
  - A subsequent read of addr 3 -> 0x0000FFFF in both modes.
- OUTPUT_REG=1: issue reads of addr 0,1,2 on consecutive cycles (contents 0xA,0xB,0xC) -> data_out=0xA,0xB,0xC on edges 2,3,4 after the first read; data_valid high for exactly those three cycles.
- Reset mid-operation, OUTPUT_REG=1, RESET_VALUE=0x5A5A5A5A:
  - Issue a read, assert rst on the next edge -> data_out=0x5A5A5A5A, data_valid=0, no valid pulse from the dropped read.
  - A write attempted during rst leaves the target word unchanged.
- Wrap/boundary with ADDRESS_WIDTH=4: write distinct values to addr 0 and addr 15, read both -> correct values, no aliasing. Then read_enable=0 for 3 cycles -> data_out held and data_valid=0.
